// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder: pitch codes,
// half-period table, FSM states and the classifier.
package tone_pkg;

  localparam logic [2:0] P_SILENT = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;
  localparam logic [2:0] P5 = 3'd5;
  localparam logic [2:0] P6 = 3'd6;
  localparam logic [2:0] P7 = 3'd7;

  localparam int unsigned H_TAB [1:7] = '{
    95548, 85136, 75839, 71582,
    63776, 56819, 50618
  };

  typedef enum logic [1:0] {
    ST_SILENT,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  // Entries sit more than 2*tol apart, so at most one hits.
  function automatic logic [2:0] classify(
    input int unsigned meas,
    input int unsigned tol,
    input int unsigned shift
  );
    logic [2:0]  c;
    int unsigned h;
    int unsigned d;
    c = P_SILENT;
    for (int k = 1; k <= 7; k++) begin
      h = H_TAB[k] >> shift;
      d = (meas >= h) ? meas - h : h - meas;
      if (d <= tol) c = 3'(k);
    end
    return c;
  endfunction

endpackage

// File: rtl/period_meter.sv
// Synchronises the tone input, strobes on every transition
// and measures the interval between strobes in clk cycles.
module period_meter #(
  parameter int unsigned SILENCE_CYC = 200000,
  parameter int unsigned CNT_W       = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wave_i,
  output logic             edge_o,
  output logic [CNT_W-1:0] meas_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] SIL = CNT_W'(SILENCE_CYC);

  logic             s1_q, s2_q, prev_q;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Left out of reset so a reset never fakes an edge.
  always_ff @(posedge clk) begin
    s1_q   <= wave_i;
    s2_q   <= s1_q;
    prev_q <= s2_q;
  end

  always_comb begin
    edge_d = s2_q ^ prev_q;
    cnt_d  = cnt_q;
    if (edge_q)
      cnt_d = CNT_W'(1);
    else if (cnt_q < SIL)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  assign edge_o    = edge_q;
  assign meas_o    = cnt_q;
  assign timeout_o = (cnt_q == SIL);

endmodule

// File: rtl/tone_decoder.sv
// Classifies a measured square wave against the pitch table
// and reports pitch, lock status and tone length.
import tone_pkg::*;

module tone_decoder #(
  parameter int unsigned TOL         = 64,
  parameter int unsigned LOCK_N      = 4,
  parameter int unsigned SILENCE_CYC = 200000,
  parameter int unsigned CNT_W       = 18,
  // Right-shift of the pitch table; 0 for real audio.
  parameter int unsigned TBL_SHIFT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wave_in,
  output logic [2:0]  pitch,
  output logic        tone_on,
  output logic        pitch_valid,
  output logic [15:0] half_cnt,
  output logic [15:0] last_halves
);

  localparam logic [3:0] LOCK_M = 4'(LOCK_N);

  logic             edge_s;
  logic             timeout_s;
  logic [CNT_W-1:0] meas_s;
  logic [2:0]       cls;
  logic [15:0]      half_inc;
  logic [3:0]       match_inc;

  state_e      state_q;
  logic [2:0]  cand_q;
  logic [3:0]  match_q;
  logic [2:0]  pitch_q;
  logic        tone_q;
  logic        pv_q;
  logic [15:0] half_q;
  logic [15:0] last_q;

  period_meter #(
    .SILENCE_CYC(SILENCE_CYC),
    .CNT_W      (CNT_W)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .wave_i   (wave_in),
    .edge_o   (edge_s),
    .meas_o   (meas_s),
    .timeout_o(timeout_s)
  );

  assign cls = classify(32'(meas_s), TOL, TBL_SHIFT);
  assign match_inc = match_q + 4'd1;
  assign half_inc = (half_q == 16'hFFFF) ?
                    half_q : half_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SILENT;
      cand_q  <= P_SILENT;
      match_q <= '0;
      pitch_q <= P_SILENT;
      tone_q  <= 1'b0;
      pv_q    <= 1'b0;
      half_q  <= '0;
      last_q  <= '0;
    end else begin
      pv_q <= 1'b0;
      unique case (state_q)
        ST_SILENT: begin
          if (edge_s) begin
            state_q <= ST_ACQUIRE;
            match_q <= '0;
            cand_q  <= P_SILENT;
          end
        end
        ST_ACQUIRE: begin
          if (edge_s) begin
            if (cls == P_SILENT) begin
              match_q <= '0;
            end else if (cls == cand_q) begin
              match_q <= match_inc;
              if (match_inc == LOCK_M) begin
                state_q <= ST_LOCKED;
                pitch_q <= cand_q;
                pv_q    <= 1'b1;
                tone_q  <= 1'b1;
                half_q  <= 16'(LOCK_N);
              end
            end else begin
              cand_q  <= cls;
              match_q <= 4'd1;
            end
          end else if (timeout_s) begin
            state_q <= ST_SILENT;
          end
        end
        ST_LOCKED: begin
          if (edge_s) begin
            if (cls == pitch_q) begin
              half_q <= half_inc;
            end else begin
              last_q  <= half_q;
              pitch_q <= P_SILENT;
              pv_q    <= 1'b1;
              tone_q  <= 1'b0;
              state_q <= ST_ACQUIRE;
              cand_q  <= cls;
              match_q <= (cls != P_SILENT) ? 4'd1 : 4'd0;
            end
          end else if (timeout_s) begin
            state_q <= ST_SILENT;
            last_q  <= half_q;
            pitch_q <= P_SILENT;
            pv_q    <= 1'b1;
            tone_q  <= 1'b0;
          end
        end
        default: state_q <= ST_SILENT;
      endcase
    end
  end

  assign pitch       = pitch_q;
  assign tone_on     = tone_q;
  assign pitch_valid = pv_q;
  assign half_cnt    = half_q;
  assign last_halves = last_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed and random tone sequences checked against a
// rule-level model of the decoder (table scaled by 2^-8).
module tb_tone_decoder;

  localparam int TOL = 4;
  localparam int LOCK_N = 4;
  localparam int SIL = 500;
  localparam int CW = 9;
  localparam int SH = 8;
  localparam int HT [1:7] = '{
    95548, 85136, 75839, 71582,
    63776, 56819, 50618
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wave_in = 1'b0;
  logic [2:0]  pitch;
  logic        tone_on;
  logic        pitch_valid;
  logic [15:0] half_cnt;
  logic [15:0] last_halves;

  always #5 clk = ~clk;

  tone_decoder #(
    .TOL(TOL), .LOCK_N(LOCK_N),
    .SILENCE_CYC(SIL), .CNT_W(CW),
    .TBL_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in),
    .pitch(pitch), .tone_on(tone_on),
    .pitch_valid(pitch_valid),
    .half_cnt(half_cnt),
    .last_halves(last_halves)
  );

  int checks = 0;
  int failures = 0;
  int gap = 0;

  int m_st = 0;
  int m_cand = 0;
  int m_match = 0;
  int m_pitch = 0;
  int m_half = 0;
  int m_last = 0;
  int m_pulses = 0;

  int pulses = 0;
  int bad = 0;
  logic [2:0] p_prev = 3'd0;
  logic pv_prev = 1'b0;
  logic rst_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst_prev) begin
      if (pitch_valid) pulses++;
      if (pitch_valid && pv_prev) bad++;
      if (pitch_valid != (pitch != p_prev)) bad++;
    end
    p_prev = pitch;
    pv_prev = pitch_valid;
    rst_prev = rst;
  end

  function automatic int hs(input int k);
    return HT[k] >> SH;
  endfunction

  function automatic int cls(input int meas);
    int d;
    for (int k = 1; k <= 7; k++) begin
      d = meas - hs(k);
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return 0;
  endfunction

  task automatic m_reset();
    m_st = 0; m_cand = 0; m_match = 0;
    m_pitch = 0; m_half = 0; m_last = 0;
  endtask

  task automatic m_timeout();
    if (m_st == 2) begin
      m_last = m_half;
      m_pitch = 0;
      m_pulses++;
    end
    m_st = 0;
  endtask

  task automatic m_edge(input int meas);
    int c;
    if (meas >= SIL) m_timeout();
    c = cls(meas);
    if (m_st == 0) begin
      m_st = 1; m_match = 0; m_cand = 0;
    end else if (m_st == 1) begin
      if (c == 0) begin
        m_match = 0;
      end else if (c == m_cand) begin
        m_match++;
        if (m_match == LOCK_N) begin
          m_st = 2;
          m_pitch = m_cand;
          m_half = LOCK_N;
          m_pulses++;
        end
      end else begin
        m_cand = c;
        m_match = 1;
      end
    end else begin
      if (c == m_pitch) begin
        if (m_half < 65535) m_half++;
      end else begin
        m_last = m_half;
        m_pitch = 0;
        m_pulses++;
        m_st = 1;
        m_cand = c;
        m_match = (c != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag);
    chk({tag, ".pitch"}, 32'(pitch), m_pitch);
    chk({tag, ".tone_on"}, 32'(tone_on),
        (m_st == 2) ? 1 : 0);
    chk({tag, ".half_cnt"}, 32'(half_cnt), m_half);
    chk({tag, ".last"}, 32'(last_halves), m_last);
    chk({tag, ".pulses"}, pulses, m_pulses);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    gap++;
  endtask

  task automatic hp(input int h);
    wave_in = ~wave_in;
    m_edge(gap);
    gap = 0;
    repeat (5) tick();
    outs("hp");
    repeat (h - 5) tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
    if (gap >= SIL + 5) m_timeout();
    outs("idle");
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, len, h;
    repeat (3) tick();
    rst = 1'b0;
    outs("reset");
    idle(3 * SIL);
    chk("idle.pulses", pulses, 0);

    repeat (11) hp(hs(5));
    chk("lock5.pitch", 32'(pitch), 5);
    chk("lock5.half", 32'(half_cnt), 10);
    idle(SIL + 10);

    repeat (9) hp(hs(1));
    chk("p1.pitch", 32'(pitch), 1);
    idle(SIL + 10);
    chk("p1.last", 32'(last_halves), 8);
    chk("p1.pitch0", 32'(pitch), 0);

    repeat (8) hp(hs(6));
    chk("sw.p6", 32'(pitch), 6);
    repeat (10) hp(hs(7));
    chk("sw.p7", 32'(pitch), 7);
    idle(SIL + 10);

    for (int i = 0; i < 10; i++)
      hp((i % 2 != 0) ? hs(5) - TOL : hs(5) + TOL);
    chk("tol.lock", 32'(pitch), 5);
    hp(hs(5) + TOL + 1);
    hp(hs(5));
    chk("tol.unlock", 32'(pitch), 0);
    idle(SIL + 10);

    repeat (8) hp(hs(3));
    chk("rst.pre", 32'(pitch), 3);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    chk("rst.pitch", 32'(pitch), 0);
    chk("rst.tone", 32'(tone_on), 0);
    chk("rst.pv", 32'(pitch_valid), 0);
    chk("rst.half", 32'(half_cnt), 0);
    chk("rst.last", 32'(last_halves), 0);
    m_reset();
    rst = 1'b0;
    repeat (4) hp(hs(3));
    chk("relock.early", 32'(tone_on), 0);
    hp(hs(3));
    chk("relock.pitch", 32'(pitch), 3);
    chk("relock.tone", 32'(tone_on), 1);
    idle(SIL + 10);

    for (int r = 0; r < 10; r++) begin
      k = int'($urandom_range(1, 7));
      len = int'($urandom_range(2, 8));
      for (int j = 0; j < len; j++) begin
        h = hs(k) - (TOL + 2) +
            int'($urandom_range(0, 2 * TOL + 4));
        hp(h);
      end
    end
    idle(SIL + 10);

    chk("pv.protocol", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
